ctl_pwm_fade_10b: RTL and testbench

Upstream stage of the 10-bit PWM output driver. Accepts a target duty value over a valid/ready handshake and slews its 10-bit output toward that target by a fixed step. The output changes only at PWM period boundaries, so the driver never sees a mid-period duty change. o_val connects directly to the driver's i_val. Both blocks share i_clk and i_rst.

---
 rtl/ctl_pwm_fade_10b.sv | 137 +++++++++++++
 tb/tb_ctl_pwm_fade_10b.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ctl_pwm_fade_10b.sv
// ctl_pwm_fade_10b: slews a 10-bit duty value toward an accepted target, updating only at PWM period ends.
// Optional macro PWM_FADE_RETARGET_EN allows a new target to be accepted mid-ramp. Rev 1.0
`default_nettype none

module ctl_pwm_fade_10b #(
   parameter int STEP     = 1,
   parameter int STEP_DIV = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_tgt,
   input  logic       i_tgt_valid,
   output logic       o_tgt_ready,
   output logic [9:0] o_val,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [9:0] STEP_V = 10'(STEP);
   localparam logic [7:0] DIV_M1 = 8'(STEP_DIV - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t      state, state_nx;
   logic [9:0]  p_cnt;
   logic [7:0]  d_cnt, d_cnt_nx;
   logic [9:0]  tgt, tgt_nx;
   logic [9:0]  val, val_nx;
   logic        busy, busy_nx;
   logic        done, done_nx;

   logic        xfer;
   logic        period_end;
   logic        up;
   logic [10:0] diff;
   logic [9:0]  stp;
   logic [9:0]  stepped;

`ifdef PWM_FADE_RETARGET_EN
   assign o_tgt_ready = ~i_rst;
`else
   assign o_tgt_ready = (state == IDLE) & ~i_rst;
`endif

   assign xfer       = i_tgt_valid & o_tgt_ready;
   assign period_end = (p_cnt == 10'd1023);

   // Step is clamped to the remaining distance, so the value can neither overshoot nor wrap.
   assign up      = (tgt > val);
   assign diff    = up ? ({1'b0, tgt} - {1'b0, val}) : ({1'b0, val} - {1'b0, tgt});
   assign stp     = ({1'b0, STEP_V} > diff) ? diff[9:0] : STEP_V;
   assign stepped = up ? (val + stp) : (val - stp);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         p_cnt <= 10'd0;
         d_cnt <= 8'd0;
         tgt   <= 10'd0;
         val   <= 10'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         p_cnt <= p_cnt + 10'd1;
         d_cnt <= d_cnt_nx;
         tgt   <= tgt_nx;
         val   <= val_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      d_cnt_nx = d_cnt;
      tgt_nx   = tgt;
      val_nx   = val;
      busy_nx  = busy;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) begin
               d_cnt_nx = 8'd0;
               if (i_tgt == val) begin
                  done_nx = 1'b1;
               end else begin
                  tgt_nx   = i_tgt;
                  state_nx = RAMP;
                  busy_nx  = 1'b1;
               end
            end
         end
         RAMP: begin
`ifdef PWM_FADE_RETARGET_EN
            // A new target wins over a coincident step event.
            if (xfer) begin
               tgt_nx   = i_tgt;
               d_cnt_nx = 8'd0;
               if (i_tgt == val) begin
                  state_nx = IDLE;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
               end
            end else
`endif
            if (period_end) begin
               if (d_cnt == DIV_M1) begin
                  d_cnt_nx = 8'd0;
                  val_nx   = stepped;
                  if (stepped == tgt) begin
                     state_nx = IDLE;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
                  end
               end else begin
                  d_cnt_nx = d_cnt + 8'd1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   assign o_val  = val;
   assign o_busy = busy;
   assign o_done = done;

endmodule

`default_nettype wire

// File: tb/tb_ctl_pwm_fade_10b.sv
// Directed bench for ctl_pwm_fade_10b: three instances (STEP/STEP_DIV = 1/1, 100/1, 1/3) sharing clock and reset.
`default_nettype none

module tb_ctl_pwm_fade_10b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] tgt  [3];
   logic       vld  [3];
   logic       rdy  [3];
   logic [9:0] val  [3];
   logic       busy [3];
   logic       done [3];

   int errors = 0;
   int checks = 0;
   logic [9:0] pc = 10'd0;

`ifdef PWM_FADE_RETARGET_EN
   localparam bit RT = 1'b1;
`else
   localparam bit RT = 1'b0;
`endif

   always #5 clk = ~clk;

   // Mirror of the free-running period counter; value after each edge equals the DUT's p_cnt.
   always @(posedge clk) pc <= rst ? 10'd0 : pc + 10'd1;

   ctl_pwm_fade_10b #(.STEP(1), .STEP_DIV(1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_tgt(tgt[0]), .i_tgt_valid(vld[0]),
      .o_tgt_ready(rdy[0]), .o_val(val[0]), .o_busy(busy[0]), .o_done(done[0]));

   ctl_pwm_fade_10b #(.STEP(100), .STEP_DIV(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_tgt(tgt[1]), .i_tgt_valid(vld[1]),
      .o_tgt_ready(rdy[1]), .o_val(val[1]), .o_busy(busy[1]), .o_done(done[1]));

   ctl_pwm_fade_10b #(.STEP(1), .STEP_DIV(3)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_tgt(tgt[2]), .i_tgt_valid(vld[2]),
      .o_tgt_ready(rdy[2]), .o_val(val[2]), .o_busy(busy[2]), .o_done(done[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pc(input logic [9:0] n);
      for (int i = 0; i < 1100 && pc != n; i++) step_clk();
      if (pc != n) begin
         checks++;
         errors++;
         $error("FAIL wait_pc: observed %0d expected %0d", pc, n);
      end
   endtask

   task automatic send(input int d, input logic [9:0] t, input string tag);
      tgt[d] = t;
      vld[d] = 1'b1;
      chk({tag, "_ready"}, {31'd0, rdy[d]}, 32'd1);
      step_clk();
      vld[d] = 1'b0;
   endtask

   // Checks the value holds through the last cycle of a period and takes its new value as p_cnt wraps to 0.
   task automatic boundary(input int d, input int prev, input int exp, input bit b, input bit dn, input string tag);
      wait_pc(10'd1023);
      chk({tag, "_hold"}, {22'd0, val[d]}, prev);
      step_clk();
      chk({tag, "_val"},  {22'd0, val[d]}, exp);
      chk({tag, "_busy"}, {31'd0, busy[d]}, {31'd0, b});
      chk({tag, "_done"}, {31'd0, done[d]}, {31'd0, dn});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         tgt[i] = 10'd0;
         vld[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) step_clk();
      chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_val",   {22'd0, val[i]}, 32'd0);
         chk("rst_busy",  {31'd0, busy[i]}, 32'd0);
         chk("rst_done",  {31'd0, done[i]}, 32'd0);
         chk("rst_rdy_hi", {31'd0, rdy[i]}, 32'd1);
      end

      // Target equal to current value: immediate done, no ramp.
      send(2, 10'd0, "eq");
      chk("eq_done",  {31'd0, done[2]}, 32'd1);
      chk("eq_busy",  {31'd0, busy[2]}, 32'd0);
      chk("eq_val",   {22'd0, val[2]}, 32'd0);
      step_clk();
      chk("eq_done_clr", {31'd0, done[2]}, 32'd0);

      // STEP_DIV=3: one step every three periods.
      send(2, 10'd2, "div");
      chk("div_busy", {31'd0, busy[2]}, 32'd1);
      boundary(2, 0, 0, 1'b1, 1'b0, "div_p1");
      boundary(2, 0, 0, 1'b1, 1'b0, "div_p2");
      boundary(2, 0, 1, 1'b1, 1'b0, "div_p3");
      boundary(2, 1, 1, 1'b1, 1'b0, "div_p4");
      boundary(2, 1, 1, 1'b1, 1'b0, "div_p5");
      boundary(2, 1, 2, 1'b0, 1'b1, "div_p6");

      // STEP=100 ramp up to 1000, clamp at 1023, then down to 50.
      send(1, 10'd1000, "b_up");
      for (int k = 1; k <= 10; k++)
         boundary(1, 100 * (k - 1), 100 * k, k < 10, k == 10, "b_up");
      send(1, 10'd1023, "b_top");
      boundary(1, 1000, 1023, 1'b0, 1'b1, "b_top");
      step_clk();
      chk("b_top_done_clr", {31'd0, done[1]}, 32'd0);
      send(1, 10'd50, "b_dn");
      for (int k = 0; k <= 8; k++)
         boundary(1, (k == 0) ? 1023 : 1023 - 100 * k, 923 - 100 * k, 1'b1, 1'b0, "b_dn");
      boundary(1, 123, 50, 1'b0, 1'b1, "b_dn_last");

      // STEP=1 ramp 0->3 starting at p_cnt=10.
      wait_pc(10'd10);
      send(0, 10'd3, "a");
      chk("a_busy0",  {31'd0, busy[0]}, 32'd1);
      chk("a_ready0", {31'd0, rdy[0]}, 32'(RT));
      for (int k = 1; k <= 3; k++) begin
         boundary(0, k - 1, k, k < 3, k == 3, "a_ramp");
         if (k < 3) chk("a_ready_ramp", {31'd0, rdy[0]}, 32'(RT));
      end
      chk("a_ready_end", {31'd0, rdy[0]}, 32'd1);
      step_clk();
      chk("a_done_clr", {31'd0, done[0]}, 32'd0);

      // Reset mid-ramp at value 5 toward 9.
      send(0, 10'd9, "r");
      boundary(0, 3, 4, 1'b1, 1'b0, "r_ramp");
      boundary(0, 4, 5, 1'b1, 1'b0, "r_ramp");
      repeat (5) step_clk();
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
      chk("r_val",  {22'd0, val[0]}, 32'd0);
      chk("r_busy", {31'd0, busy[0]}, 32'd0);
      chk("r_done", {31'd0, done[0]}, 32'd0);
      step_clk();
      chk("r_done2", {31'd0, done[0]}, 32'd0);
      boundary(0, 0, 0, 1'b0, 1'b0, "r_idle");

      // Ramp 0->9, new target 2 offered at value 4.
      wait_pc(10'd10);
      send(0, 10'd9, "rt");
      for (int k = 1; k <= 4; k++)
         boundary(0, k - 1, k, 1'b1, 1'b0, "rt_ramp");
      wait_pc(10'd20);
      tgt[0] = 10'd2;
      vld[0] = 1'b1;
      chk("rt_ready", {31'd0, rdy[0]}, 32'(RT));
      step_clk();
      vld[0] = 1'b0;
      chk("rt_busy", {31'd0, busy[0]}, 32'd1);
      chk("rt_val",  {22'd0, val[0]}, 32'd4);
      if (RT) begin
         boundary(0, 4, 3, 1'b1, 1'b0, "rt_new");
         boundary(0, 3, 2, 1'b0, 1'b1, "rt_new");
      end else begin
         for (int k = 5; k <= 9; k++)
            boundary(0, k - 1, k, k < 9, k == 9, "rt_keep");
      end
      step_clk();
      chk("rt_done_clr", {31'd0, done[0]}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
